// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Registered ready (no combinational ready chain); hazard unit flush/freeze with selectable priority.
module pipe_stage_skid_reg #(
  parameter int                DATA_W        = 32,
  parameter bit                FLUSH_PRIO    = 1'b1,
  parameter bit                ZERO_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_vld, s_vld;
  logic [DATA_W-1:0] m_dat, s_dat;
  logic              m_vld_n, s_vld_n;
  logic [DATA_W-1:0] m_dat_n, s_dat_n;
  logic              fl, fz;
  logic              in_fire, out_fire;

  always_comb begin
    if (FLUSH_PRIO) begin
      fl = flush;
      fz = freeze & ~flush;
    end else begin
      fz = freeze;
      fl = flush & ~freeze;
    end
  end

  // Ready looks only at the skid slot and hazard controls, so a downstream stall is absorbed by s.
  assign in_ready  = ~rst & ~s_vld & ~fz & ~fl;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_vld & out_ready & ~fz & ~fl;
  assign out_valid = m_vld;
  assign out_data  = m_dat;
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

  always_comb begin
    m_vld_n = m_vld;
    s_vld_n = s_vld;
    m_dat_n = m_dat;
    s_dat_n = s_dat;
    if (fl) begin
      m_vld_n = 1'b0;
      s_vld_n = 1'b0;
      if (ZERO_ON_FLUSH) begin
        m_dat_n = '0;
        s_dat_n = '0;
      end
    end else if (!fz) begin
      if (!m_vld) begin
        if (in_fire) begin
          m_vld_n = 1'b1;
          m_dat_n = in_data;
        end
      end else if (!out_fire) begin
        if (in_fire) begin
          s_vld_n = 1'b1;
          s_dat_n = in_data;
        end
      end else if (s_vld) begin
        m_dat_n = s_dat;
        s_vld_n = 1'b0;
      end else if (in_fire) begin
        m_dat_n = in_data;
      end else begin
        m_vld_n = 1'b0;
      end
    end
  end

  // Stage register boundary: main and skid slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= RESET_VAL;
      s_dat <= RESET_VAL;
    end else begin
      m_vld <= m_vld_n;
      s_vld <= s_vld_n;
      m_dat <= m_dat_n;
      s_dat <= s_dat_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: three parameter variants driven in parallel, checked
// against a FIFO-queue reference model, a vector table and directed corner sequences.
module tb_pipe_stage_skid_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, freeze, in_valid, out_ready;
  logic [7:0] in_data;
  logic       ir  [3];
  logic       ov  [3];
  logic [7:0] od  [3];
  logic [1:0] occ [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(8), .FLUSH_PRIO(1'b1), .ZERO_ON_FLUSH(1'b1), .RESET_VAL(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ[0]));

  pipe_stage_skid_reg #(.DATA_W(8), .FLUSH_PRIO(1'b0), .ZERO_ON_FLUSH(1'b1), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ[1]));

  pipe_stage_skid_reg #(.DATA_W(8), .FLUSH_PRIO(1'b1), .ZERO_ON_FLUSH(1'b0), .RESET_VAL(8'h00)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .occupancy(occ[2]));

  // Reference model: each instance is a FIFO of at most two entries.
  logic [7:0] mq  [3][2];
  int         msz [3];
  bit         prio [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fz;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] eocc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) msz[k] = 0;
  endfunction

  function automatic void eff_ctl(input int k, output bit efl, output bit efz);
    if (prio[k]) begin efl = flush; efz = freeze && !flush; end
    else         begin efz = freeze; efl = flush && !freeze; end
  endfunction

  task automatic model_check();
    bit efl, efz;
    for (int k = 0; k < 3; k++) begin
      eff_ctl(k, efl, efz);
      chk($sformatf("m%0d_in_ready", k), 32'(ir[k]), 32'(!rst && msz[k] < 2 && !efl && !efz));
      chk($sformatf("m%0d_out_valid", k), 32'(ov[k]), 32'(msz[k] > 0));
      chk($sformatf("m%0d_occupancy", k), 32'(occ[k]), 32'(msz[k]));
      if (msz[k] > 0) chk($sformatf("m%0d_out_data", k), 32'(od[k]), 32'(mq[k][0]));
    end
  endtask

  function automatic void model_update();
    bit efl, efz, rdy;
    for (int k = 0; k < 3; k++) begin
      eff_ctl(k, efl, efz);
      if (efl) msz[k] = 0;
      else if (!efz) begin
        rdy = (msz[k] < 2);
        if (out_ready && msz[k] > 0) begin
          mq[k][0] = mq[k][1];
          msz[k]--;
        end
        if (in_valid && rdy) begin
          mq[k][msz[k]] = in_data;
          msz[k]++;
        end
      end
    end
  endfunction

  // Called at posedge+1: drive inputs, move to the falling edge and check against the model.
  task automatic apply(input logic iv, input logic [7:0] d, input logic ordy, input logic fl, input logic fz);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; freeze = fz;
    #4;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 0; flush = 0; freeze = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy, input logic fz,
                              input logic eir, input logic eov, input logic [7:0] eod, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fz = fz;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eocc = eocc;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 8'h11, 1, 0, 1, 0, 8'hFF, 0);
    tbl[1]  = mk(1, 8'h22, 1, 0, 1, 1, 8'h11, 1);
    tbl[2]  = mk(1, 8'h33, 1, 0, 1, 1, 8'h22, 1);
    tbl[3]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    tbl[4]  = mk(1, 8'hA1, 0, 0, 1, 0, 8'h33, 0);
    tbl[5]  = mk(1, 8'hA2, 0, 0, 1, 1, 8'hA1, 1);
    tbl[6]  = mk(1, 8'hA3, 0, 0, 0, 1, 8'hA1, 2);
    tbl[7]  = mk(0, 8'h00, 1, 0, 0, 1, 8'hA1, 2);
    tbl[8]  = mk(0, 8'h00, 1, 0, 1, 1, 8'hA2, 1);
    tbl[9]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA2, 0);
    tbl[10] = mk(1, 8'h5C, 0, 0, 1, 0, 8'hA2, 0);
    tbl[11] = mk(1, 8'h66, 1, 1, 0, 1, 8'h5C, 1);
    tbl[12] = mk(1, 8'h66, 1, 1, 0, 1, 8'h5C, 1);
    tbl[13] = mk(1, 8'h66, 1, 1, 0, 1, 8'h5C, 1);
    tbl[14] = mk(0, 8'h00, 1, 0, 1, 1, 8'h5C, 1);
    tbl[15] = mk(0, 8'h00, 0, 0, 1, 0, 8'h5C, 0);

    do_reset();
    chk("reset_out_data_a", 32'(od[0]), 32'hFF);
    chk("reset_out_data_b", 32'(od[1]), 32'h00);

    // Streaming, backpressure and freeze vectors
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0, tbl[i].fz);
      chk($sformatf("tbl%0d_in_ready", i), 32'(ir[0]), 32'(tbl[i].eir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov[0]), 32'(tbl[i].eov));
      chk($sformatf("tbl%0d_out_data", i), 32'(od[0]), 32'(tbl[i].eod));
      chk($sformatf("tbl%0d_occupancy", i), 32'(occ[0]), 32'(tbl[i].eocc));
      advance();
    end

    // Flush together with freeze while both slots are full
    apply(1, 8'hB1, 0, 0, 0); advance();
    apply(1, 8'hB2, 0, 0, 0); advance();
    chk("prefl_occ_a", 32'(occ[0]), 32'd2);
    apply(1, 8'hB3, 1, 1, 1); advance();
    chk("flfz_occ_prio1", 32'(occ[0]), 32'd0);
    chk("flfz_valid_prio1", 32'(ov[0]), 32'd0);
    chk("flfz_data_zeroed", 32'(od[0]), 32'h00);
    chk("flfz_occ_prio0", 32'(occ[1]), 32'd2);
    chk("flfz_data_prio0", 32'(od[1]), 32'hB1);
    chk("flfz_data_kept", 32'(od[2]), 32'hB1);
    apply(0, 8'h00, 0, 1, 0); advance();
    chk("fl_occ_prio0", 32'(occ[1]), 32'd0);

    // Flush without zeroing keeps the payload visible
    apply(1, 8'h7E, 0, 0, 0); advance();
    apply(0, 8'h00, 0, 1, 0); advance();
    chk("nozero_valid", 32'(ov[2]), 32'd0);
    chk("nozero_data", 32'(od[2]), 32'h7E);
    chk("zero_data", 32'(od[0]), 32'h00);

    // Asynchronous reset under backpressure
    apply(1, 8'hC1, 0, 0, 0); advance();
    apply(1, 8'hC2, 0, 0, 0); advance();
    chk("prerst_occ", 32'(occ[0]), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ov[0]), 32'd0);
    chk("arst_occupancy", 32'(occ[0]), 32'd0);
    chk("arst_out_data", 32'(od[0]), 32'hFF);
    chk("arst_in_ready", 32'(ir[0]), 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    apply(1, 8'h01, 0, 0, 0);
    chk("postrst_in_ready", 32'(ir[0]), 32'd1);
    advance();
    chk("postrst_valid", 32'(ov[0]), 32'd1);
    chk("postrst_data", 32'(od[0]), 32'h01);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register for the processor pipeline. It supersedes the fixed-field stage registers with a single generic block that carries an arbitrary packed payload. The block adds a valid/ready handshake with a 2-entry skid buffer, configurable flush/freeze priority, optional data zeroing, and an occupancy output. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The hazard unit drives flush and freeze.

Parameters:
DATA_W, 32, payload width in bits (any value >= 1)
FLUSH_PRIO, 1, 1 = flush overrides freeze; 0 = freeze overrides flush (legacy stage-register ordering)
ZERO_ON_FLUSH, 1, 1 = data registers cleared on flush; 0 = only valid bits cleared on flush, data retained
RESET_VAL, 0, DATA_W-bit value loaded into both data registers on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all held and incoming entries this cycle
freeze  in  1  stall: hold all state, block both handshakes
in_valid  in  1  upstream entry present
in_ready  out  1  block can accept an entry this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  main register holds a valid entry
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main register payload
occupancy  out  2  number of held entries: 0, 1 or 2

Behaviour:
- State: main register (m_vld, m_dat) and skid register (s_vld, s_dat). out_valid = m_vld; out_data = m_dat.
- Reset (async): m_vld = s_vld = 0; m_dat = s_dat = RESET_VAL; occupancy = 0; in_ready = 0 while rst is high.
- Effective controls:
  - FLUSH_PRIO=1: fl = flush; fz = freeze & ~flush.
  - FLUSH_PRIO=0: fz = freeze; fl = flush & ~freeze.
- in_ready = ~s_vld & ~fz & ~fl (combinational, no path from in_valid).
- Fire signals: in_fire = in_valid & in_ready; out_fire = m_vld & out_ready & ~fz & ~fl.
- fl cycle: m_vld <= 0, s_vld <= 0. The incoming entry is dropped (in_ready=0). If ZERO_ON_FLUSH=1, m_dat and s_dat <= 0; otherwise data is unchanged.
- fz cycle: all registers hold; no in_fire or out_fire. out_valid stays visible, but out_ready is ignored.
- Normal cycle (neither fl nor fz):
  - m empty, in_fire: m <= in. Latency is 1 cycle.
  - m full, no out_fire, in_fire: s <= in (s must be empty, guaranteed by in_ready).
  - m full, out_fire, s full: m <= s; s_vld <= 0 (no in_fire possible).
  - m full, out_fire, s empty, in_fire: m <= in (full throughput, 1 entry/cycle).
  - m full, out_fire, s empty, no in_fire: m_vld <= 0.
  - otherwise: hold.
- Invariants:
  - s_vld implies m_vld.
  - Ordering is strictly FIFO.
  - No entry is duplicated or lost except on fl.
  - occupancy = m_vld + s_vld, registered state.
- in_ready depends only on registered state and freeze/flush. A downstream stall therefore propagates upstream with a 1-cycle skid, with no combinational ready chain.
- Reset asserted mid-transfer: all state clears immediately. On the first edge after rst deasserts, in_ready = 1 if neither flush nor freeze is asserted.
- Simultaneous flush and freeze:
  - FLUSH_PRIO=1: the flush is taken.
  - FLUSH_PRIO=0: the freeze is taken and the flush is lost. The hazard unit must hold flush until freeze drops.

Test Plan:
- Streaming (DATA_W=8): out_ready=1 throughout; send 0x11, 0x22, 0x33 on consecutive cycles -> each appears on out_data one cycle after acceptance; in_ready stays 1; occupancy is never 2.
- Backpressure: out_ready=0; send 0xA1 then 0xA2 -> occupancy=2 and in_ready=0. Raise out_ready -> 0xA1 is seen, then 0xA2, in order; in_ready returns to 1 the cycle after the first out_fire.
- Freeze: occupancy=1 holding 0x5C; freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_data stays 0x5C, out_valid=1, occupancy stays 1. Drop freeze -> 0x5C is consumed on the next edge.
- Flush priority: occupancy=2; assert flush and freeze together.
  - FLUSH_PRIO=1 -> next cycle occupancy=0, out_valid=0, out_data=0x00.
  - FLUSH_PRIO=0 -> occupancy stays 2.
- ZERO_ON_FLUSH=0: hold 0x7E, flush -> out_valid=0 and out_data still 0x7E.
- Async reset with RESET_VAL=0xFF mid-backpressure (occupancy=2): assert rst off a clock edge -> outputs go immediately to out_valid=0, occupancy=0, out_data=0xFF. After release, a new entry 0x01 is accepted.
